// File: rtl/lane_rx_deser.sv
// lane_rx_deser: oversampling receiver for the 1-bit serial lane.
// Synchronises the lane, deserialises start/data/parity/stop frames
// and queues good words in a first-word-fall-through FIFO.
module lane_rx_deser #(
  parameter int DATA_W     = 8,
  parameter int OVS        = 4,
  parameter int PARITY_EN  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          lane_in,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int CW = $clog2(OVS);
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  localparam logic [CW-1:0] CNT_HALF = CW'(OVS / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVS - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t            state;
  logic [1:0]        sync_q;
  logic              s;
  logic [CW-1:0]     cnt;
  logic [BW-1:0]     bitcnt;
  logic [DATA_W-1:0] data_q;
  logic              par_q;
  logic              parity_ok;
  logic              stop_sample;
  logic              push;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     level;
  logic              pop;
  logic              full;
  logic              accept;

  // Two-flop synchroniser; resets to the idle-high lane level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], lane_in};
  end

  assign s = sync_q[1];

  // Even parity: data bits plus parity bit must XOR to zero.
  assign parity_ok   = (PARITY_EN == 0) || !(^{data_q, par_q});
  assign stop_sample = (state == S_STOP) && (cnt == CNT_LAST);
  assign push        = stop_sample && s && parity_ok;

  // Frame FSM: bit timing, deserialisation and registered error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bitcnt     <= '0;
      data_q     <= '0;
      par_q      <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      // NOTE: every state register uses <= so all reads in this block see the
      // pre-edge value; a blocking = here would make later reads order-dependent.
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!s) begin
            state <= S_START;
            cnt   <= '0;
          end
        end
        S_START: begin
          if (cnt == CNT_HALF) begin
            if (s) begin
              state <= S_IDLE;
            end else begin
              state  <= S_DATA;
              cnt    <= '0;
              bitcnt <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt    <= '0;
            data_q <= {s, data_q[DATA_W-1:1]};
            if (bitcnt == BIT_LAST) state  <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
            else                    bitcnt <= bitcnt + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            par_q <= s;
            state <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (s) begin
              state      <= S_IDLE;
              parity_err <= !parity_ok;
            end else begin
              state     <= S_BREAK;
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_BREAK: begin
          if (s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign out_valid = (level != '0);
  assign pop       = out_valid && out_ready;
  assign full      = (level == LW'(FIFO_DEPTH));
  assign accept    = push && (!full || pop);

  // FIFO storage write; a simultaneous pop frees the slot being written when full.
  // NOTE: storage has no reset; occupancy is tracked by level, so stale entries are never observed.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= data_q;
  end

  // FIFO pointers, occupancy and the overflow pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push && !accept;
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign out_data   = out_valid ? mem[rd_ptr] : '0;
  assign fifo_level = level;

endmodule

// File: tb/tb_lane_rx_deser.sv
// tb_lane_rx_deser: scenario tasks drive serial frames; expected words are
// queued at send time and matched against FIFO output beats by a monitor.
module tb_lane_rx_deser;

  localparam int DATA_W = 8;
  localparam int OVS    = 4;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              lane_in;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              frame_err;
  logic              parity_err;
  logic              overflow;
  logic [2:0]        fifo_level;

  int pass_cnt = 0;
  int total_cnt = 0;
  int fe_cnt = 0;
  int pe_cnt = 0;
  int ov_cnt = 0;
  logic [DATA_W-1:0] exp_q[$];

  lane_rx_deser #(
    .DATA_W(DATA_W), .OVS(OVS), .PARITY_EN(1), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .lane_in(lane_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .frame_err(frame_err), .parity_err(parity_err), .overflow(overflow),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  // Monitor: sampled on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_err)  fe_cnt++;
      if (parity_err) pe_cnt++;
      if (overflow)   ov_cnt++;
      if (out_valid) begin
        total_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_word got %02h expected none", out_data);
        end else if (out_data !== exp_q[0]) begin
          $display("FAIL word_data got %02h expected %02h", out_data, exp_q[0]);
        end else begin
          pass_cnt++;
        end
        if (out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
  end

  task automatic drive_bit(input logic b);
    lane_in = b;
    repeat (OVS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < DATA_W; i++) drive_bit(d[i]);
    drive_bit((^d) ^ bad_par);
    drive_bit(stop);
  endtask

  task automatic settle();
    repeat (12) @(negedge clk);
  endtask

  task automatic clear_counts();
    fe_cnt = 0;
    pe_cnt = 0;
    ov_cnt = 0;
  endtask

  // Waits (bounded) for every queued word to be delivered.
  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL %s_drain got %0d pending expected 0", name, exp_q.size());
    else pass_cnt++;
    settle();
  endtask

  task automatic expect_counts(input string name, input int fe, input int pe, input int ov, input int lvl);
    total_cnt++;
    if (fe_cnt !== fe || pe_cnt !== pe || ov_cnt !== ov)
      $display("FAIL %s_pulses got fe=%0d pe=%0d ov=%0d expected fe=%0d pe=%0d ov=%0d",
               name, fe_cnt, pe_cnt, ov_cnt, fe, pe, ov);
    else pass_cnt++;
    total_cnt++;
    if (fifo_level !== 3'(lvl)) $display("FAIL %s_level got %0d expected %0d", name, fifo_level, lvl);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    lane_in = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({out_data, out_valid, frame_err, parity_err, overflow, fifo_level} !== '0)
      $display("FAIL reset_outputs got %0h expected 0",
               {out_data, out_valid, frame_err, parity_err, overflow, fifo_level});
    else pass_cnt++;
    rst_n = 1'b1;
    settle();
    expect_counts("reset", 0, 0, 0, 0);
  endtask

  task automatic test_basic();
    clear_counts();
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b0, 1'b1);
    drain("basic");
    expect_counts("basic", 0, 0, 0, 0);
  endtask

  task automatic test_parity_err();
    clear_counts();
    send_frame(8'h01, 1'b1, 1'b1);
    settle();
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL parity_valid got %0b expected 0", out_valid);
    else pass_cnt++;
    expect_counts("parity", 0, 1, 0, 0);
  endtask

  task automatic test_frame_err();
    clear_counts();
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    expect_counts("break", 1, 0, 0, 0);
    lane_in = 1'b1;
    repeat (OVS) @(negedge clk);
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b0, 1'b1);
    drain("after_break");
    expect_counts("after_break", 1, 0, 0, 0);
  endtask

  task automatic test_glitch();
    clear_counts();
    lane_in = 1'b0;
    repeat (OVS / 2) @(negedge clk);
    lane_in = 1'b1;
    settle();
    expect_counts("glitch", 0, 0, 0, 0);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b0, 1'b1);
    drain("glitch_next");
    expect_counts("glitch_next", 0, 0, 0, 0);
  endtask

  task automatic test_back_to_back_overflow();
    clear_counts();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < DEPTH) exp_q.push_back(8'(8'h10 + i));
      send_frame(8'(8'h10 + i), 1'b0, 1'b1);
    end
    settle();
    expect_counts("overflow", 0, 0, 1, DEPTH);
    total_cnt++;
    if (out_data !== 8'h10) $display("FAIL overflow_head got %02h expected 10", out_data);
    else pass_cnt++;
    out_ready = 1'b1;
    drain("overflow");
    expect_counts("overflow_drained", 0, 0, 1, 0);
  endtask

  task automatic test_mid_reset();
    clear_counts();
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    rst_n = 1'b0;
    lane_in = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({out_data, out_valid, frame_err, parity_err, overflow, fifo_level} !== '0)
      $display("FAIL midreset_outputs got %0h expected 0",
               {out_data, out_valid, frame_err, parity_err, overflow, fifo_level});
    else pass_cnt++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    settle();
    expect_counts("midreset", 0, 0, 0, 0);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b0, 1'b1);
    drain("midreset_next");
    expect_counts("midreset_next", 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity_err();
    test_frame_err();
    test_glitch();
    test_back_to_back_overflow();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
